// File: rtl/cache_arbiter.sv
//------------------------------------------------------------------------------
// Module      : cache_arbiter
// Description : Two-requester front end for a cache controller, with a WAIT
//               timeout and a saturating miss counter. Define CACHE_ARB_RR_EN
//               for round-robin arbitration; otherwise r0 has fixed priority.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cache_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    output logic          r0_gnt,
    output logic          r0_done,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic [DW-1:0] rd_data,
    output logic          c_req,
    output logic [AW-1:0] c_addr,
    input  logic          c_done,
    input  logic          c_miss,
    input  logic [DW-1:0] c_rdata,
    output logic [15:0]   miss_cnt,
    output logic          tmo_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TMO - 1);

    state_t        r_state;
    logic          r_owner;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_miss;
    logic [7:0]    r_cnt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          r_creq;
    logic          r_tmo;
    logic          w_win;

`ifdef CACHE_ARB_RR_EN
    // r_prio names the requester that wins the next simultaneous request
    logic r_prio;

    assign w_win = r1_req & (~r0_req | r_prio);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= 1'b0;
        end else if (r_state == ST_IDLE && (r0_req || r1_req)) begin
            r_prio <= ~w_win;
        end
    end
`else
    assign w_win = r1_req & ~r0_req;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_miss  <= '0;
            r_cnt   <= '0;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_creq  <= 1'b0;
            r_tmo   <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            r_creq <= 1'b0;
            r_tmo  <= 1'b0;
            if (r_state == ST_WAIT && c_miss && r_miss != 16'hFFFF) begin
                r_miss <= r_miss + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r0_req || r1_req) begin
                        r_state <= ST_ISSUE;
                        r_owner <= w_win;
                        r_addr  <= w_win ? r1_addr : r0_addr;
                        r_gnt0  <= ~w_win;
                        r_gnt1  <= w_win;
                        r_creq  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= '0;
                end
                ST_WAIT: begin
                    // a completion on the final timeout cycle still counts as done
                    if (c_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == c_tmo_last) begin
                        r_state <= ST_IDLE;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign r0_gnt   = r_gnt0;
    assign r1_gnt   = r_gnt1;
    assign c_req    = r_creq;
    assign c_addr   = r_addr;
    assign miss_cnt = r_miss;
    assign tmo_err  = r_tmo;
    assign rd_data  = c_rdata;
    assign r0_done  = (r_state == ST_WAIT) & ~r_owner & c_done;
    assign r1_done  = (r_state == ST_WAIT) &  r_owner & c_done;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_cache_arbiter
// Description : Directed self-checking bench for cache_arbiter (TMO=8 main
//               instance, TMO=255 instance for miss-counter saturation).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r1_req, r0_gnt, r1_gnt, r0_done, r1_done;
    logic [31:0] r0_addr, r1_addr, rd_data, c_addr, c_rdata;
    logic        c_req, c_done, c_miss, tmo_err;
    logic [15:0] miss_cnt;

    logic        s_req, s_miss, s_r0_gnt, s_r1_gnt, s_r0_done, s_r1_done;
    logic        s_c_req, s_tmo_err;
    logic [31:0] s_rd_data, s_c_addr;
    logic [15:0] s_miss_cnt;
    logic [31:0] s_c_rdata = 32'h0000_5A5A;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.AW(32), .DW(32), .TMO(8)) u_dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_done(r0_done),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_done(r1_done),
        .rd_data(rd_data), .c_req(c_req), .c_addr(c_addr), .c_done(c_done),
        .c_miss(c_miss), .c_rdata(c_rdata), .miss_cnt(miss_cnt), .tmo_err(tmo_err)
    );

    cache_arbiter #(.AW(32), .DW(32), .TMO(255)) u_sat (
        .clk(clk), .reset(reset),
        .r0_req(s_req), .r0_addr(32'h0), .r0_gnt(s_r0_gnt), .r0_done(s_r0_done),
        .r1_req(1'b0), .r1_addr(32'h0), .r1_gnt(s_r1_gnt), .r1_done(s_r1_done),
        .rd_data(s_rd_data), .c_req(s_c_req), .c_addr(s_c_addr), .c_done(1'b0),
        .c_miss(s_miss), .c_rdata(s_c_rdata), .miss_cnt(s_miss_cnt), .tmo_err(s_tmo_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [5:0] pulses();
        return {r0_gnt, r1_gnt, r0_done, r1_done, c_req, tmo_err};
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; r0_req = 1'b0; r1_req = 1'b0; r0_addr = '0; r1_addr = '0;
        c_done = 1'b1; c_miss = 1'b0; c_rdata = 32'hDEAD_BEEF;
        s_req = 1'b0; s_miss = 1'b1;

        // reset state, with a stray c_done held during reset
        repeat (3) @(posedge clk);
        mid();
        check("rst_pulses", 32'(pulses()), 32'h0);
        check("rst_miss", 32'(miss_cnt), 32'h0);
        check("rst_caddr", c_addr, 32'h0);
        cyc(); reset = 1'b0; c_done = 1'b0;
        mid();
        check("post_rst_pulses", 32'(pulses()), 32'h0);

        // single r0 access, misses in WAIT, r1 arriving while busy
        cyc(); r0_req = 1'b1; r0_addr = 32'h100;
        mid(); check("idle_no_gnt", 32'(r0_gnt), 32'h0);
        cyc(); mid();
        check("issue_gnt_creq", {30'h0, r0_gnt, c_req}, 32'h3);
        check("issue_r1_gnt", 32'(r1_gnt), 32'h0);
        check("issue_caddr", c_addr, 32'h100);
        cyc(); r0_req = 1'b0; c_miss = 1'b1;
        mid(); check("wait_no_done", 32'(r0_done), 32'h0);
        cyc(); c_miss = 1'b0; r1_req = 1'b1; r1_addr = 32'h2A0;
        mid(); check("pend_no_gnt_a", 32'(r1_gnt), 32'h0);
        cyc(); c_miss = 1'b1;
        mid(); check("pend_no_gnt_b", {31'h0, r1_gnt | c_req}, 32'h0);
        cyc(); c_miss = 1'b0; c_done = 1'b1;
        mid();
        check("done_vec", {30'h0, r0_done, r1_done}, 32'h2);
        check("done_rdata", rd_data, 32'hDEAD_BEEF);
        check("done_caddr", c_addr, 32'h100);
        cyc(); c_done = 1'b0;
        mid();
        check("miss_two", 32'(miss_cnt), 32'h2);
        check("idle_after_done", 32'(pulses()), 32'h0);

        // pending r1 granted, then left to time out
        cyc(); mid();
        check("r1_gnt_vec", {30'h0, r0_gnt, r1_gnt}, 32'h1);
        check("r1_caddr", c_addr, 32'h2A0);
        cyc(); r1_req = 1'b0;
        repeat (7) cyc();
        mid(); check("tmo_not_yet", {31'h0, tmo_err | r1_done}, 32'h0);
        cyc(); r0_req = 1'b1; r0_addr = 32'h3C0;
        mid(); check("tmo_pulse", {29'h0, tmo_err, c_req, r1_done}, 32'h4);
        cyc(); mid();
        check("tmo_one_cycle", 32'(tmo_err), 32'h0);
        check("gnt_after_tmo", 32'(r0_gnt), 32'h1);

        // c_done on the exact timeout cycle wins
        cyc(); r0_req = 1'b0;
        repeat (6) cyc();
        cyc(); c_done = 1'b1;
        mid(); check("edge_done", 32'(r0_done), 32'h1);
        cyc(); c_done = 1'b0;
        mid(); check("edge_no_tmo", {31'h0, tmo_err | r0_done}, 32'h0);

        // c_done and c_miss in IDLE are ignored
        cyc(); c_done = 1'b1;
        mid(); check("idle_done_ignored", {30'h0, r0_done, r1_done}, 32'h0);
        cyc(); c_done = 1'b0; c_miss = 1'b1;
        mid(); check("idle_stays", 32'(c_req), 32'h0);
        cyc(); c_miss = 1'b0;
        mid(); check("idle_miss_ignored", 32'(miss_cnt), 32'h2);

        // reset in the middle of WAIT, stale c_done afterwards
        cyc(); r0_req = 1'b1;
        cyc(); mid(); check("pre_rst_gnt", 32'(r0_gnt), 32'h1);
        cyc(); r0_req = 1'b0; c_miss = 1'b1;
        cyc(); c_miss = 1'b0;
        mid(); check("pre_rst_miss", 32'(miss_cnt), 32'h3);
        cyc(); reset = 1'b1;
        cyc();
        mid();
        check("mid_rst_pulses", 32'(pulses()), 32'h0);
        check("mid_rst_miss", 32'(miss_cnt), 32'h0);
        check("mid_rst_caddr", c_addr, 32'h0);
        cyc(); reset = 1'b0;
        mid(); check("rel_pulses", 32'(pulses()), 32'h0);
        cyc();
        cyc(); c_done = 1'b1;
        mid(); check("stale_done", 32'(pulses()), 32'h0);
        cyc(); c_done = 1'b0;

        // both requesters held together for four transactions
        cyc(); r0_req = 1'b1; r1_req = 1'b1; r0_addr = 32'h400; r1_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            int n;
`ifdef CACHE_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            n = 0;
            mid();
            while (c_req !== 1'b1 && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("arb_creq_seen", 32'(n < 8), 32'h1);
            check("arb_gnt", {30'h0, r1_gnt, r0_gnt}, {30'h0, exp_g});
            check("arb_caddr", c_addr, exp_g[1] ? 32'h500 : 32'h400);
            cyc(); c_done = 1'b1;
            mid(); check("arb_done", {30'h0, r1_done, r0_done}, {30'h0, exp_g});
            cyc(); c_done = 1'b0;
            if (k == 3) begin
                r0_req = 1'b0;
                r1_req = 1'b0;
            end
        end

        // saturation on the TMO=255 instance; c_miss has been high while idle
        mid(); check("sat_idle_miss", 32'(s_miss_cnt), 32'h0);
        cyc(); s_req = 1'b1;
        repeat (257) @(posedge clk);
        mid();
        check("sat_first_txn", 32'(s_miss_cnt), 32'd255);
        check("sat_tmo", 32'(s_tmo_err), 32'h1);
        repeat (67000) @(posedge clk);
        mid(); check("sat_full", 32'(s_miss_cnt), 32'hFFFF);
        repeat (300) @(posedge clk);
        mid(); check("sat_hold", 32'(s_miss_cnt), 32'hFFFF);
        check("sat_quiet", {29'h0, s_r1_gnt, s_r0_done, s_r1_done}, 32'h0);
        check("sat_caddr", s_c_addr, 32'h0);
        check("sat_rdata", s_rd_data, 32'h0000_5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter AW, default 32: address width of requester and cache ports.
REQ-002 Parameter DW, default 32: read-data width.
REQ-003 Parameter TMO, default 255: WAIT-state timeout in cycles, range 1..255.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rN_req  input  1  requester N (N=0,1) access request; held high until rN_gnt is seen.
REQ-007 rN_addr  input  AW  requester N address; valid while rN_req=1.
REQ-008 rN_gnt  output  1  one-cycle pulse: requester N won arbitration, and its address is captured.
REQ-009 rN_done  output  1  one-cycle pulse: requester N access complete, and rd_data is valid.
REQ-010 rd_data  output  DW  pass-through of c_rdata.
REQ-011 c_req  output  1  one-cycle start pulse to the cache controller.
REQ-012 c_addr  output  AW  captured address; stable from ISSUE until the return to IDLE.
REQ-013 c_done  input  1  cache controller completion pulse.
REQ-014 c_miss  input  1  cache controller miss indication (ReadBlk entered); one pulse per miss.
REQ-015 c_rdata  input  DW  cache read data; valid with c_done.
REQ-016 miss_cnt  output  16  saturating count of misses.
REQ-017 tmo_err  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT, encoded in 2 bits.
REQ-019 IDLE SHALL move to ISSUE at an edge where r0_req|r1_req=1, capturing the winner as owner and its address into c_addr.
REQ-020 IDLE with no request SHALL remain in IDLE.
REQ-021 ISSUE SHALL last exactly one cycle, assert c_req=1 and rOwner_gnt=1 during it, then go to WAIT.
REQ-022 WAIT SHALL go to IDLE at an edge where c_done=1; rOwner_done=c_done in WAIT (combinational), and non-owner done SHALL stay 0.
REQ-023 Latency: request sampled at edge N -> gnt/c_req in cycle N..N+1 -> earliest done in the cycle after ISSUE; minimum 3 cycles between grants.
REQ-024 c_done outside WAIT SHALL be ignored: no done pulse, no state change.
REQ-025 c_miss SHALL increment miss_cnt only in WAIT; at 16'hFFFF it SHALL hold.
REQ-026 A WAIT cycle counter SHALL clear on entry to WAIT; if TMO cycles elapse without c_done, the FSM SHALL pulse tmo_err for one cycle, return to IDLE, and assert no done.
REQ-027 If c_done and the timeout coincide, c_done SHALL win: done pulses, no tmo_err.
REQ-028 A requester request arriving while not IDLE SHALL be held pending, with no gnt, until the next IDLE.
REQ-029 Outputs rN_gnt, c_req and tmo_err SHALL be Moore (state-decoded or registered); only rN_done and rd_data are combinational.

Reset
REQ-030 On reset=1 at an edge: state=IDLE, owner=0, c_addr=0, miss_cnt=0, WAIT counter=0, rr pointer=0.
REQ-031 While reset is held and in the first cycle after it: all gnt/done/c_req/tmo_err = 0.
REQ-032 Reset mid-transaction SHALL abandon it silently, with no done and no tmo_err; a later stale c_done is ignored per REQ-024.

Configuration
REQ-033 Macro CACHE_ARB_RR_EN defined: round-robin, where a simultaneous request goes to the requester not granted last (pointer updated on each grant; after reset r0 wins first).
REQ-034 Macro CACHE_ARB_RR_EN undefined: fixed priority, where r0 always wins simultaneous requests and there is no pointer register.

Verification
REQ-035 Single r0_req with addr 0x100, c_done 4 cycles after c_req -> r0_gnt and c_req in the same cycle, c_addr=0x100, r0_done with rd_data=c_rdata, r1 outputs 0.
REQ-036 r0_req and r1_req held together for 4 transactions -> RR build grants r0,r1,r0,r1; fixed build grants r0 four times while r1 never granted.
REQ-037 c_done never returned, TMO=8 -> tmo_err pulses after 8 WAIT cycles, FSM back in IDLE, no done.
REQ-038 70000 c_miss pulses in WAIT -> miss_cnt=0xFFFF and holds; c_miss pulse in IDLE does not count.
REQ-039 reset asserted in WAIT, c_done pulsed 2 cycles after reset release -> no rN_done, state IDLE, miss_cnt=0.
REQ-040 c_done on the exact timeout cycle -> done pulses, tmo_err stays 0.
